// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, with a one-entry response register.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build gives requester 0 fixed priority.
module alu_arbiter #(
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned RR_RESET = 0
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_aluop,
    input  logic [31:0]      req0_vsrc1,
    input  logic [31:0]      req0_vsrc2,
    input  logic [4:0]       req0_vshift,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic             rsp0_overflow,
    output logic [TAG_W-1:0] rsp0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_aluop,
    input  logic [31:0]      req1_vsrc1,
    input  logic [31:0]      req1_vsrc2,
    input  logic [4:0]       req1_vshift,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic             rsp1_overflow,
    output logic [TAG_W-1:0] rsp1_tag,

    output logic [3:0]       alu_aluop,
    output logic [31:0]      alu_vsrc1,
    output logic [31:0]      alu_vsrc2,
    output logic [4:0]       alu_vshift,
    input  logic [31:0]      alu_result,
    input  logic             alu_overflow,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        result_q, result_d;
    logic               overflow_q, overflow_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic               slot_free;
    logic               gnt0;
    logic               gnt1;

`ifdef ALU_ARB_RR_EN
    logic               rr_q, rr_d;
`else
    logic               unused_rr;
    assign unused_rr = 1'(RR_RESET);
`endif

    // A held result accepted this cycle frees the slot for a same-cycle grant.
    always_comb begin
        slot_free = (state_q == IDLE)
                  | ((state_q == HOLD0) & rsp0_ready)
                  | ((state_q == HOLD1) & rsp1_ready);
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef ALU_ARB_RR_EN
        gnt0 = slot_free & req0_valid & (~req1_valid | ~rr_q);
        gnt1 = slot_free & req1_valid & (~req0_valid |  rr_q);
`else
        gnt0 = slot_free & req0_valid;
        gnt1 = slot_free & req1_valid & ~req0_valid;
`endif
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        tag_d      = tag_q;
        alu_aluop  = 4'd0;
        alu_vsrc1  = 32'd0;
        alu_vsrc2  = 32'd0;
        alu_vshift = 5'd0;
`ifdef ALU_ARB_RR_EN
        rr_d       = rr_q;
`endif
        if (gnt0) begin
            alu_aluop  = req0_aluop;
            alu_vsrc1  = req0_vsrc1;
            alu_vsrc2  = req0_vsrc2;
            alu_vshift = req0_vshift;
            state_d    = HOLD0;
            result_d   = alu_result;
            overflow_d = alu_overflow;
            tag_d      = req0_tag;
`ifdef ALU_ARB_RR_EN
            rr_d       = 1'b1;
`endif
        end else if (gnt1) begin
            alu_aluop  = req1_aluop;
            alu_vsrc1  = req1_vsrc1;
            alu_vsrc2  = req1_vsrc2;
            alu_vshift = req1_vshift;
            state_d    = HOLD1;
            result_d   = alu_result;
            overflow_d = alu_overflow;
            tag_d      = req1_tag;
`ifdef ALU_ARB_RR_EN
            rr_d       = 1'b0;
`endif
        end else if (slot_free) begin
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            result_q   <= 32'd0;
            overflow_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            tag_q      <= tag_d;
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= 1'(RR_RESET);
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Both channels see the shared register; only the owner's valid is raised.
    assign req0_ready    = gnt0;
    assign req1_ready    = gnt1;
    assign rsp0_valid    = (state_q == HOLD0);
    assign rsp1_valid    = (state_q == HOLD1);
    assign rsp0_result   = result_q;
    assign rsp1_result   = result_q;
    assign rsp0_overflow = overflow_q;
    assign rsp1_overflow = overflow_q;
    assign rsp0_tag      = tag_q;
    assign rsp1_tag      = tag_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;

    localparam int unsigned TW     = 4;
    localparam int unsigned RR_RST = 0;
`ifdef ALU_ARB_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_overflow;
    logic [3:0]    req0_aluop;
    logic [31:0]   req0_vsrc1, req0_vsrc2, rsp0_result;
    logic [4:0]    req0_vshift;
    logic [TW-1:0] req0_tag, rsp0_tag;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_overflow;
    logic [3:0]    req1_aluop;
    logic [31:0]   req1_vsrc1, req1_vsrc2, rsp1_result;
    logic [4:0]    req1_vshift;
    logic [TW-1:0] req1_tag, rsp1_tag;
    logic [3:0]    alu_aluop;
    logic [31:0]   alu_vsrc1, alu_vsrc2, alu_result;
    logic [4:0]    alu_vshift;
    logic          alu_overflow;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;

    // Transaction-level model: who owns the held response, its contents, and the preferred requester.
    int            m_own;
    logic [31:0]   m_res;
    logic          m_ovf;
    logic [TW-1:0] m_tag;
    logic          m_ptr;
    logic          last_rdy0, last_rdy1;

    alu_arbiter #(.TAG_W(TW), .RR_RESET(RR_RST)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_vsrc1(req0_vsrc1), .req0_vsrc2(req0_vsrc2), .req0_vshift(req0_vshift),
        .req0_tag(req0_tag), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_overflow(rsp0_overflow), .rsp0_tag(rsp0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_vsrc1(req1_vsrc1), .req1_vsrc2(req1_vsrc2), .req1_vshift(req1_vshift),
        .req1_tag(req1_tag), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_overflow(rsp1_overflow), .rsp1_tag(rsp1_tag),
        .alu_aluop(alu_aluop), .alu_vsrc1(alu_vsrc1), .alu_vsrc2(alu_vsrc2),
        .alu_vshift(alu_vshift), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {overflow, result}; opcodes 1100-1111 return zero.
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        logic        v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            4'd0:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2:  r = {31'd0, $signed(a) < $signed(b)};
            4'd3:  r = {31'd0, a < b};
            4'd4:  r = a & b;
            4'd5:  r = ~(a | b);
            4'd6:  r = a | b;
            4'd7:  r = a ^ b;
            4'd8:  r = b << sh;
            4'd9:  r = b >> sh;
            4'd10: r = 32'($signed(b) >>> sh);
            4'd11: r = {b[15:0], 16'd0};
            default: r = 32'd0;
        endcase
        return {v, r};
    endfunction

    always_comb {alu_overflow, alu_result} = alu_ref(alu_aluop, alu_vsrc1, alu_vsrc2, alu_vshift);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_aluop = 4'd0; req0_vsrc1 = 32'd0; req0_vsrc2 = 32'd0;
        req0_vshift = 5'd0; req0_tag = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_aluop = 4'd0; req1_vsrc1 = 32'd0; req1_vsrc2 = 32'd0;
        req1_vshift = 5'd0; req1_tag = '0; rsp1_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_own = -1;
        m_res = 32'd0;
        m_ovf = 1'b0;
        m_tag = '0;
        m_ptr = 1'(RR_RST);
    endtask

    // Called just after a falling edge: checks the cycle against the model, then advances one clock.
    task automatic step();
        int          g;
        bit          free;
        logic [32:0] r;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_sh;
        #1;
        free = (m_own < 0) || (m_own == 0 && rsp0_ready) || (m_own == 1 && rsp1_ready);
        g = -1;
        if (free) begin
            if (req0_valid && req1_valid) g = RR_BUILD ? int'(m_ptr) : 0;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
        end
        e_op = 4'd0; e_a = 32'd0; e_b = 32'd0; e_sh = 5'd0;
        if (g == 0) begin e_op = req0_aluop; e_a = req0_vsrc1; e_b = req0_vsrc2; e_sh = req0_vshift; end
        if (g == 1) begin e_op = req1_aluop; e_a = req1_vsrc1; e_b = req1_vsrc2; e_sh = req1_vshift; end

        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        check("alu_aluop",  64'(alu_aluop),  64'(e_op));
        check("alu_vsrc1",  64'(alu_vsrc1),  64'(e_a));
        check("alu_vsrc2",  64'(alu_vsrc2),  64'(e_b));
        check("alu_vshift", 64'(alu_vshift), 64'(e_sh));
        check("rsp0_valid", 64'(rsp0_valid), 64'(m_own == 0));
        check("rsp1_valid", 64'(rsp1_valid), 64'(m_own == 1));
        check("busy",       64'(busy),       64'(m_own >= 0));
        if (m_own == 0) begin
            check("rsp0_result",   64'(rsp0_result),   64'(m_res));
            check("rsp0_overflow", 64'(rsp0_overflow), 64'(m_ovf));
            check("rsp0_tag",      64'(rsp0_tag),      64'(m_tag));
        end
        if (m_own == 1) begin
            check("rsp1_result",   64'(rsp1_result),   64'(m_res));
            check("rsp1_overflow", 64'(rsp1_overflow), 64'(m_ovf));
            check("rsp1_tag",      64'(rsp1_tag),      64'(m_tag));
        end
        last_rdy0 = req0_ready;
        last_rdy1 = req1_ready;

        if (g >= 0) begin
            r     = alu_ref(e_op, e_a, e_b, e_sh);
            m_own = g;
            m_res = r[31:0];
            m_ovf = r[32];
            m_tag = (g == 0) ? req0_tag : req1_tag;
            m_ptr = (g == 0) ? 1'b1 : 1'b0;
        end else if (free) begin
            m_own = -1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse away from the rising edge; outputs must clear before any clock.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        check("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_rsp0_valid",  64'(rsp0_valid),    64'd0);
        check("reset_rsp1_valid",  64'(rsp1_valid),    64'd0);
        check("reset_rsp0_result", 64'(rsp0_result),   64'd0);
        check("reset_rsp0_ovf",    64'(rsp0_overflow), 64'd0);
        check("reset_rsp0_tag",    64'(rsp0_tag),      64'd0);
        check("reset_busy",        64'(busy),          64'd0);
        reset = 1'b0;

        // Add overflow, one-cycle latency, then release to idle.
        req0_valid = 1'b1; req0_aluop = 4'd0; req0_vsrc1 = 32'h7FFF_FFFF; req0_vsrc2 = 32'd1;
        req0_tag = 4'd3; rsp0_ready = 1'b1;
        step();
        req0_valid = 1'b0;
        check("add_valid",  64'(rsp0_valid),    64'd1);
        check("add_result", 64'(rsp0_result),   64'h8000_0000);
        check("add_ovf",    64'(rsp0_overflow), 64'd1);
        check("add_tag",    64'(rsp0_tag),      64'd3);
        step();
        check("add_idle",   64'(busy),          64'd0);

        // Four cycles of contention, starting from the reset pointer.
        do_reset();
        clear_inputs();
        req0_valid = 1'b1; req0_aluop = 4'd6; req0_vsrc1 = 32'hF0; req0_vsrc2 = 32'h0F;
        req1_valid = 1'b1; req1_aluop = 4'd8; req1_vsrc2 = 32'd1; req1_vshift = 5'd4;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (RR_BUILD && (i % 2 == 1)) begin
                check("cont_rsp1_valid", 64'(rsp1_valid),  64'd1);
                check("cont_rsp1_res",   64'(rsp1_result), 64'h10);
            end else begin
                check("cont_rsp0_valid", 64'(rsp0_valid),  64'd1);
                check("cont_rsp0_res",   64'(rsp0_result), 64'hFF);
            end
        end
        clear_inputs();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step();

        // Held response back-pressures the other requester until accepted.
        req1_valid = 1'b1; req1_aluop = 4'd1; req1_vsrc1 = 32'd5; req1_vsrc2 = 32'd7; req1_tag = 4'd9;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_aluop = 4'd0; req0_vsrc1 = 32'd1; req0_vsrc2 = 32'd1; req0_tag = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rdy0",   64'(last_rdy0),   64'd0);
            check("hold_result", 64'(rsp1_result), 64'hFFFF_FFFE);
        end
        rsp1_ready = 1'b1;
        step();
        check("release_rdy0", 64'(last_rdy0),   64'd1);
        check("release_res",  64'(rsp0_result), 64'd2);
        req0_valid = 1'b0; rsp0_ready = 1'b1;
        step();

        // Back-to-back lui then sltu with no bubble.
        req0_valid = 1'b1; req0_aluop = 4'd11; req0_vsrc1 = 32'd0; req0_vsrc2 = 32'h1234; rsp0_ready = 1'b1;
        step();
        check("lui_result", 64'(rsp0_result), 64'h1234_0000);
        req0_aluop = 4'd3; req0_vsrc1 = 32'd1; req0_vsrc2 = 32'd2;
        step();
        check("sltu_rdy0",   64'(last_rdy0),   64'd1);
        check("sltu_result", 64'(rsp0_result), 64'd1);
        check("sltu_valid",  64'(rsp0_valid),  64'd1);
        req0_aluop = 4'd13;
        step();
        check("illegal_res", 64'(rsp0_result), 64'd0);
        req0_valid = 1'b0;
        step();

        // Reset while a result is held for requester 0.
        req0_valid = 1'b1; req0_aluop = 4'd7; req0_vsrc1 = 32'hA5; req0_vsrc2 = 32'h5A; rsp0_ready = 1'b0;
        step();
        check("hold0_valid", 64'(rsp0_valid), 64'd1);
        clear_inputs();
        do_reset();
        req1_valid = 1'b1; req1_aluop = 4'd4; req1_vsrc1 = 32'hFF; req1_vsrc2 = 32'h0F; rsp1_ready = 1'b1;
        step();
        check("postrst_rdy1",  64'(last_rdy1),   64'd1);
        check("postrst_valid", 64'(rsp1_valid),  64'd1);
        check("postrst_res",   64'(rsp1_result), 64'h0F);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            req0_valid  = ($urandom_range(0, 99) < 60);
            req0_aluop  = 4'($urandom_range(0, 15));
            req0_vsrc1  = rand_opnd();
            req0_vsrc2  = rand_opnd();
            req0_vshift = 5'($urandom_range(0, 31));
            req0_tag    = TW'($urandom);
            rsp0_ready  = ($urandom_range(0, 99) < 70);
            req1_valid  = ($urandom_range(0, 99) < 60);
            req1_aluop  = 4'($urandom_range(0, 15));
            req1_vsrc1  = rand_opnd();
            req1_vsrc2  = rand_opnd();
            req1_vshift = 5'($urandom_range(0, 31));
            req1_tag    = TW'($urandom);
            rsp1_ready  = ($urandom_range(0, 99) < 70);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single ALU instance between two requesters: requester 0 is the execute stage and requester 1 is the address/branch-compare helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block grants one request per cycle and drives the ALU combinationally from the granted operands.
- It captures the ALU result and overflow into a one-entry response register until the owning requester accepts it.

Parameters:
TAG_W, 4, width of the opaque transaction tag returned unchanged with each response
RR_RESET, 0, requester given priority on the first contended cycle after reset (round-robin build only)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_aluop  in  4  ALU opcode (0000 add ... 1011 lui)
req0_vsrc1  in  32  operand 1
req0_vsrc2  in  32  operand 2
req0_vshift  in  5  shift amount
req0_tag  in  TAG_W  transaction tag
rsp0_valid  out  1  result pending for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  32  captured ALU result
rsp0_overflow  out  1  captured ALU overflow
rsp0_tag  out  TAG_W  tag of captured operation
req1_* / rsp1_*  same set as requester 0, for requester 1
alu_aluop  out  4  to shared ALU
alu_vsrc1  out  32  to shared ALU
alu_vsrc2  out  32  to shared ALU
alu_vshift  out  5  to shared ALU
alu_result  in  32  from shared ALU (combinational)
alu_overflow  in  1  from shared ALU
busy  out  1  response register occupied

Behaviour:
- Clock and reset: single clock `clk`; reset `reset` is asynchronous and active-high.
- Reset state: state IDLE; rsp*_valid=0; rsp*_result=0; rsp*_overflow=0; rsp*_tag=0; busy=0; RR pointer=RR_RESET.
- States:
  - IDLE: response register empty.
  - HOLD0: result held for requester 0.
  - HOLD1: result held for requester 1.
- slot_free = IDLE | (HOLD0 & rsp0_ready) | (HOLD1 & rsp1_ready). A slot freed by acceptance is reusable in the same cycle, giving full throughput of one op per cycle.
- Grant:
  - When slot_free and at least one req*_valid, exactly one requester is granted; its req*_ready=1 and the other's is 0.
  - When not slot_free, both ready=0.
  - ready depends on valid only through arbitration: no ready toggling while slot_free with a single requester valid.
- Arbitration (default build): fixed priority, requester 0 wins on contention.
- ALU drive:
  - The granted request's aluop/vsrc1/vsrc2/vshift go to the alu_* ports in the grant cycle.
  - With no grant, alu_aluop=0 and operands=0.
- Capture:
  - On grant, next edge loads result, overflow and tag from alu_result/alu_overflow/granted tag.
  - State goes to HOLDn for granted requester n.
  - Latency: request accepted cycle N -> rsp valid cycle N+1.
- Release: in HOLDn with rsp_n_ready=1 and no new grant -> IDLE; with a new grant -> HOLDm (m may equal n).
- Stable outputs: rsp*_result/overflow/tag stay stable while rsp*_valid=1 and not accepted. The non-owning rsp*_valid is always 0.
- rsp_ready on the non-owning channel is ignored.
- busy = (state != IDLE).
- No arithmetic in this block. Overflow is passed through unmasked; the ALU already qualifies it to add/sub.
- Reset mid-operation: pending response is discarded, state IDLE, no response emitted.
- Illegal aluop values (1100-1111): forwarded unchanged; the ALU returns 0 and the block returns that.

Optional Feature:
- Macro: ALU_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer names the preferred requester on contention. After each grant, the pointer moves to the non-granted requester. Uncontended grants also update the pointer.
- Undefined: fixed priority to requester 0; RR_RESET unused; no pointer flop.

Test Plan:
- Reset asserted mid-HOLD0 -> rsp0_valid drops asynchronously to 0, busy=0, and after release the first req1 is granted in the next cycle.
- req0 add vsrc1=0x7FFFFFFF vsrc2=1 tag=3, rsp0_ready=1 -> next cycle rsp0_valid=1, result=0x80000000, overflow=1, tag=3, then IDLE.
- Both valid for 4 cycles (req0 or 0xF0/0x0F, req1 sll vsrc2=1 vshift=4), both rsp_ready=1, fixed-priority build -> four rsp0 results 0x000000FF in a row and no req1 grant. Round-robin build with RR_RESET=0 -> responses alternate 0,1,0,1 with results 0xFF,0x10.
- req1 sub 5-7 accepted, rsp1_ready=0 for 3 cycles with req0 valid -> req0_ready=0 throughout, and rsp1_result holds 0xFFFFFFFE. When rsp1_ready=1, req0 is granted that same cycle.
- Back-to-back req0 lui vsrc2=0x1234 then sltu 1<2 with rsp0_ready=1 -> consecutive cycles give 0x12340000 then 0x00000001, with no bubble.
